div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a division.
REQ-005 The block SHALL have port X1, input, WIDTH, unsigned dividend.
REQ-006 The block SHALL have port X2, input, WIDTH, unsigned divisor.
REQ-007 The block SHALL have port Q, output, WIDTH, registered quotient.
REQ-008 The block SHALL have port R, output, WIDTH, registered remainder.
REQ-009 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when Q/R become valid.
REQ-011 The block SHALL have port div_zero, output, 1, registered flag set with done when X2 was 0.

Function
REQ-012 Operation SHALL be unsigned restoring division, one quotient bit per CALC cycle, MSB first.
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 In IDLE, start=1 at a clock edge SHALL latch X1 and X2, clear partial remainder and bit counter, and go to CALC if X2!=0.
REQ-015 Each CALC edge SHALL shift {rem, dividend} left by 1, then subtract divisor from rem if rem>=divisor and set the new quotient LSB to 1, else 0.
REQ-016 Rem SHALL be held at WIDTH+1 bits internally so the compare never overflows.
REQ-017 After the WIDTH-th CALC edge the FSM SHALL enter DONE, load Q and R, and clear div_zero.
REQ-018 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH (k+32 at default).
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-020 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored, with latched operands unaffected.
REQ-022 Divide-by-zero: start with X2=0 in IDLE SHALL go directly to DONE with Q=all ones, R=X1, div_zero=1 (done one cycle after the start edge).
REQ-023 Q, R and div_zero SHALL hold their values until the next completion or reset.
REQ-024 start asserted in the DONE cycle SHALL be ignored; back-to-back operations begin from IDLE.
REQ-025 Operands SHALL be sampled only at the accepting edge; X1/X2 changes afterwards SHALL have no effect.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force state to IDLE and Q=0, R=0, busy=0, done=0, div_zero=0, and clear the counter and internal registers.
REQ-027 Reset mid-operation SHALL abort the division with no done pulse; the first start after rst_n returns to 1 SHALL behave as from power-up.

Structure
REQ-028 A shared package SHALL hold the state enum type (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-029 A combinational sub-module div_step SHALL implement one shift/compare/subtract step (inputs rem, next dividend bit, divisor; outputs new rem, quotient bit).
REQ-030 The bit counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-031 X1=100, X2=7, start for 1 cycle -> done in the cycle after edge k+32 with Q=14, R=2, div_zero=0, and busy high for 33 cycles.
REQ-032 X1=32'hFFFFFFFF, X2=1 -> Q=32'hFFFFFFFF, R=0; X1=5, X2=10 -> Q=0, R=5.
REQ-033 X1=1234, X2=0 -> done one cycle after start with Q=32'hFFFFFFFF, R=1234, div_zero=1; the next valid division clears div_zero.
REQ-034 start for 100/7, then at cycle 10 start with X1=9, X2=3 -> second request ignored; result Q=14, R=2.
REQ-035 Reset asserted at cycle 15 of a division -> no done pulse, all outputs 0; a new start of 50/5 -> Q=10, R=0 with normal latency.
REQ-036 Random regression: 10k unsigned pairs with X2!=0 -> Q==X1/X2 and R==X1%X2 at each done, and exactly one done per accepted start.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package div_iter_pkg;

    // Default operand / result width in bits.
    localparam int DEFAULT_WIDTH = 32;

    // Controller states: waiting, shifting out quotient bits, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor when it fits and report the resulting quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    // Shifted remainder is one bit wider than the stored remainder so the
    // compare sees the full value even if the stored top bit were ever set.
    logic [WIDTH+1:0] shifted;
    logic             fits;

    // Compare and conditional subtract of the divisor.
    always_comb begin
        shifted = {rem_in, bit_in};
        fits    = (shifted >= {2'b00, divisor});
        q_bit   = fits;
        if (fits) begin
            rem_out = shifted[WIDTH:0] - {1'b0, divisor};
        end else begin
            rem_out = shifted[WIDTH:0];
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB
// first, with a registered divide-by-zero shortcut.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] X2,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] dvd_reg;   // dividend shifts out MSB first, quotient shifts in
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dz_reg;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] dvd_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_reg),
        .bit_in  (dvd_reg[WIDTH-1]),
        .divisor (dsr_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign dvd_next = {dvd_reg[WIDTH-2:0], step_q};

    // Controller and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            dsr_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dvd_reg  <= X1;
                        dsr_reg  <= X2;
                        rem_reg  <= '0;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (X2 == '0) begin
                            // No iterations needed: report saturated quotient at once.
                            q_reg     <= '1;
                            r_reg     <= X1;
                            dz_reg    <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    dvd_reg <= dvd_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        q_reg     <= dvd_next;
                        r_reg     <= step_rem[WIDTH-1:0];
                        dz_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Start is not sampled here; a new request waits for IDLE.
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Q        = q_reg;
    assign R        = r_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = dz_reg;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for the iterative divider.
module tb_div_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] X1;
    logic [31:0] X2;
    logic [31:0] Q;
    logic [31:0] R;
    logic        busy;
    logic        done;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .X1       (X1),
        .X2       (X2),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Issue one division and follow it to completion.
    // lat: edges after the accepting edge until done is seen (32 normal, 0 div-by-zero).
    // inj: cycle index at which a second start (9/3) is driven while busy, -1 for none.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic dz,
                           input int lat, input int inj);
        int n;
        int busy_cnt;
        bit got;
        @(negedge clk);
        X1 = a; X2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        X1 = $urandom; X2 = $urandom;   // late operand changes must not matter
        n = 0; busy_cnt = 0; got = 0;
        while (!got && n < 100) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1;
            end else begin
                if (n == inj) begin
                    X1 = 32'd9; X2 = 32'd3; start = 1'b1;
                end else if (n == inj + 1) begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_q"}, Q, eq);
            check({tag, "_r"}, R, er);
            check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
            check({tag, "_lat"}, n, lat);
            check({tag, "_busycyc"}, busy_cnt, lat + 1);
            // Start held during the done cycle must be ignored.
            X1 = 32'd77; X2 = 32'd0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_hold_q"}, Q, eq);
        end
        $display("div %s: %0d / %0d -> Q=%0d R=%0d dz=%0d lat=%0d", tag, a, b, Q, R, div_zero, n);
    endtask

    initial begin
        int seen_done;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; start = 1'b0; X1 = '0; X2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", Q, 32'd0);
        check("rst_r", R, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        run_div("d100_7",   32'd100,        32'd7,          32'd14,         32'd2,    1'b0, 32, -1);
        run_div("dmax_1",   32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,    1'b0, 32, -1);
        run_div("d5_10",    32'd5,          32'd10,         32'd0,          32'd5,    1'b0, 32, -1);
        run_div("dzero",    32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234, 1'b1, 0,  -1);
        run_div("d1000_10", 32'd1000,       32'd10,         32'd100,        32'd0,    1'b0, 32, -1);
        run_div("dmax_max", 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,    1'b0, 32, -1);
        run_div("dmsb_3",   32'h80000000,   32'd3,          32'd715827882,  32'd2,    1'b0, 32, -1);
        run_div("d0_5",     32'd0,          32'd5,          32'd0,          32'd0,    1'b0, 32, -1);
        run_div("d7_7",     32'd7,          32'd7,          32'd1,          32'd0,    1'b0, 32, -1);
        run_div("dignore",  32'd100,        32'd7,          32'd14,         32'd2,    1'b0, 32, 10);

        // Reset in the middle of a division: abort, no done pulse.
        @(negedge clk);
        X1 = 32'd100; X2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_q", Q, 32'd0);
        check("mrst_r", R, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("mrst_nodone", seen_done, 32'd0);
        run_div("d50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32, -1);

        // Short random sweep against the language's own divide.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(31, 0);
            if (rb == 0) rb = 32'd1;
            run_div("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 32, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
